// File: rtl/sample_strobe_gen_pkg.sv
// Shared types and configuration check for sample_strobe_gen.
package sample_strobe_gen_pkg;
  localparam int unsigned MAX_CHANNELS = 8;
  localparam int unsigned MAX_DIV_W    = 16;
  localparam int unsigned MAX_CNT_W    = 32;

  // IDLE: wait for start | RUN: count points | DRAIN: flush log channels | DONE: end pulse
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef logic [MAX_DIV_W-1:0] div_word_t;

  // Sized for the largest supported instance; narrower instances zero-fill the upper bits.
  typedef struct packed {
    div_word_t [MAX_CHANNELS-1:0] div;
    div_word_t [MAX_CHANNELS-1:0] phase;
    logic [MAX_CNT_W-1:0]         points;
    logic                         mode;
  } cfg_t;

  function automatic logic cfg_bad(input cfg_t cfg, input int unsigned n_chan);
    logic bad;
    bad = !cfg.mode && (cfg.points == '0);
    for (int unsigned k = 0; k < MAX_CHANNELS; k++) begin
      if ((k < n_chan) && ((cfg.div[k] == '0) || (cfg.phase[k] >= cfg.div[k])))
        bad = 1'b1;
    end
    return bad;
  endfunction
endpackage

// File: rtl/sample_strobe_gen_if.sv
// Control and status bundle between sample_strobe_gen and the logic it paces.
interface sample_strobe_gen_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned CNT_W    = 32
) ();
  logic                      enable;
  logic                      start;
  logic                      abort;
  logic                      mode_i;
  logic [CHANNELS*DIV_W-1:0] div_i;
  logic [CHANNELS*DIV_W-1:0] phase_i;
  logic [CNT_W-1:0]          points_i;
  logic [CHANNELS-1:0]       strobe_o;
  logic                      busy_o;
  logic                      done_o;
  logic [CNT_W-1:0]          point_cnt_o;
  logic                      cfg_err_o;

  modport master (
    output enable, start, abort, mode_i, div_i, phase_i, points_i,
    input  strobe_o, busy_o, done_o, point_cnt_o, cfg_err_o
  );

  modport slave (
    input  enable, start, abort, mode_i, div_i, phase_i, points_i,
    output strobe_o, busy_o, done_o, point_cnt_o, cfg_err_o
  );
endinterface

// File: rtl/sample_strobe_gen_chan.sv
// One strobe channel: wrapping divide counter, phase compare and gated strobe.
module strobe_chan #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic             i_live,
  input  logic [DIV_W-1:0] i_div,
  input  logic [DIV_W-1:0] i_phase,
  output logic             o_strobe
);
  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_adv) begin
      r_cnt <= (r_cnt == i_div - DIV_W'(1)) ? '0 : r_cnt + DIV_W'(1);
    end
  end

  assign o_strobe = i_live && (r_cnt == i_phase);
endmodule

// File: rtl/sample_strobe_gen.sv
// Run sequencer around CHANNELS strobe channels: FSM, point counter, drain tracking.
module sample_strobe_gen
  import sample_strobe_gen_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned CNT_W    = 32
) (
  input logic                clk,
  input logic                rst,
  sample_strobe_gen_if.slave bus
);
  localparam logic [CHANNELS-1:0] PEND_INIT = ~CHANNELS'(1);

  state_e              r_state, w_state_nxt;
  cfg_t                r_cfg, w_cfg_in;
  logic [CNT_W-1:0]    r_pt_cnt;
  logic [CHANNELS-1:0] r_pend;
  logic                r_tick;
  logic                r_cfg_err;
  logic [CHANNELS-1:0] w_strobe;
  logic                w_busy, w_start_ok, w_start_bad, w_adv, w_last_pt;
  logic                w_unused_cfg;

  always_comb begin
    w_cfg_in = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_cfg_in.div[k][DIV_W-1:0]   = bus.div_i[k*DIV_W +: DIV_W];
      w_cfg_in.phase[k][DIV_W-1:0] = bus.phase_i[k*DIV_W +: DIV_W];
    end
    w_cfg_in.points[CNT_W-1:0] = bus.points_i;
    w_cfg_in.mode              = bus.mode_i;
  end

  assign w_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_start_ok  = (r_state == ST_IDLE) && bus.start && !cfg_bad(w_cfg_in, CHANNELS);
  assign w_start_bad = (r_state == ST_IDLE) && bus.start && cfg_bad(w_cfg_in, CHANNELS);
  assign w_adv       = w_busy && bus.enable && !bus.abort;
  assign w_last_pt   = !r_cfg.mode && (r_pt_cnt == r_cfg.points[CNT_W-1:0] - CNT_W'(1));

  // r_tick marks cycles whose counter value was just reached, so a paused counter sitting on its phase does not re-strobe.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    strobe_chan #(.DIV_W(DIV_W)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_start_ok),
      .i_adv    (w_adv),
      .i_live   (r_tick && ((k != 0) || (r_state == ST_RUN))),
      .i_div    (r_cfg.div[k][DIV_W-1:0]),
      .i_phase  (r_cfg.phase[k][DIV_W-1:0]),
      .o_strobe (w_strobe[k])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.abort)                     w_state_nxt = ST_IDLE;
        else if (w_strobe[0] && w_last_pt) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.abort)                          w_state_nxt = ST_IDLE;
        else if ((r_pend & ~w_strobe) == '0)    w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cfg     <= '0;
      r_pt_cnt  <= '0;
      r_pend    <= '0;
      r_tick    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_start_ok ||
                 (w_adv && ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN)));
      if (w_start_ok) begin
        r_cfg     <= w_cfg_in;
        r_pt_cnt  <= '0;
        r_cfg_err <= 1'b0;
      end else if (w_start_bad) begin
        r_cfg_err <= 1'b1;
      end
      if ((r_state == ST_RUN) && w_strobe[0] && !bus.abort)
        r_pt_cnt <= r_pt_cnt + CNT_W'(1);
      if ((r_state == ST_RUN) && (w_state_nxt == ST_DRAIN))
        r_pend <= PEND_INIT;
      else if (r_state == ST_DRAIN)
        r_pend <= r_pend & ~w_strobe;
    end
  end

  assign bus.strobe_o    = w_strobe;
  assign bus.busy_o      = w_busy;
  assign bus.done_o      = (r_state == ST_DONE);
  assign bus.point_cnt_o = r_pt_cnt;
  assign bus.cfg_err_o   = r_cfg_err;
  assign w_unused_cfg    = ^r_cfg;
endmodule
